// File: rtl/ic_trace_buf_if.sv
// ic_trace_buf_if: capture and drain port bundle for ic_trace_buf.
//   cap_valid/cap_tag/cap_data/freeze : event capture side (driven by master)
//   out_valid/out_ready/out_*         : show-ahead valid/ready drain port
//   level/ovf                         : occupancy and sticky overflow status
// master = producer/consumer (bench or host design), slave = ic_trace_buf.
interface ic_trace_buf_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned TS_W   = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DROP_W = 8
);
    logic                     cap_valid;
    logic [TAG_W-1:0]         cap_tag;
    logic [DATA_W-1:0]        cap_data;
    logic                     freeze;
    logic                     out_valid;
    logic                     out_ready;
    logic [TAG_W-1:0]         out_tag;
    logic [DATA_W-1:0]        out_data;
    logic [TS_W-1:0]          out_ts;
    logic [DROP_W-1:0]        out_drops;
    logic [$clog2(DEPTH):0]   level;
    logic                     ovf;

    modport master (
        output cap_valid, cap_tag, cap_data, freeze, out_ready,
        input  out_valid, out_tag, out_data, out_ts, out_drops, level, ovf
    );

    modport slave (
        input  cap_valid, cap_tag, cap_data, freeze, out_ready,
        output out_valid, out_tag, out_data, out_ts, out_drops, level, ovf
    );
endinterface

// File: rtl/ic_trace_buf.sv
// ic_trace_buf: timestamps one-cycle debug events, buffers them in a FIFO
// and drains them through a show-ahead valid/ready port.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : ic_trace_buf_if.slave (capture inputs, drain port, level, ovf)
// Each record carries the number of events dropped on overflow just before it.
module ic_trace_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 8,
    parameter int unsigned TS_W   = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DROP_W = 8
) (
    input logic           clk,
    input logic           rst,
    ic_trace_buf_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [TAG_W-1:0]  tag_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem  [DEPTH];
    logic [TS_W-1:0]   ts_mem    [DEPTH];
    logic [DROP_W-1:0] drops_mem [DEPTH];

    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [LVL_W-1:0]  level_q;
    logic [TS_W-1:0]   ts_q;
    logic [DROP_W-1:0] drop_cnt_q;
    logic              ovf_q;

    logic full;
    logic capture;
    logic pop;
    logic push;
    logic drop;

    always_comb begin
        full    = (level_q == LVL_W'(DEPTH));
        capture = bus.cap_valid && !bus.freeze;
        pop     = (level_q != '0) && bus.out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        push    = capture && (!full || pop);
        drop    = capture && !push;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            level_q    <= '0;
            ts_q       <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (push) begin
                tail_q     <= tail_q + PTR_W'(1);
                drop_cnt_q <= '0;
            end else if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + DROP_W'(1);
            end
            if (drop) begin
                ovf_q <= 1'b1;
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage is not reset; control state alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            tag_mem[tail_q]   <= bus.cap_tag;
            data_mem[tail_q]  <= bus.cap_data;
            ts_mem[tail_q]    <= ts_q;
            drops_mem[tail_q] <= drop_cnt_q;
        end
    end

    // Head fields are forced to zero when empty so reset leaves out_* at 0.
    always_comb begin
        bus.out_valid = (level_q != '0);
        bus.out_tag   = bus.out_valid ? tag_mem[head_q]   : '0;
        bus.out_data  = bus.out_valid ? data_mem[head_q]  : '0;
        bus.out_ts    = bus.out_valid ? ts_mem[head_q]    : '0;
        bus.out_drops = bus.out_valid ? drops_mem[head_q] : '0;
        bus.level     = level_q;
        bus.ovf       = ovf_q;
    end
endmodule

// File: tb/tb_ic_trace_buf.sv
// Scoreboard bench for ic_trace_buf: each step drives inputs at the falling
// edge, predicts push/pop/drop, queues expected records and compares the head
// record whenever a handshake happens.
module tb_ic_trace_buf;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 8;
    localparam int unsigned TS_W   = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DROP_W = 8;

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] data;
        logic [31:0] ts;
        logic [7:0]  drops;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ic_trace_buf_if #(
        .DATA_W(DATA_W), .TAG_W(TAG_W), .TS_W(TS_W), .DEPTH(DEPTH), .DROP_W(DROP_W)
    ) bus ();

    ic_trace_buf #(
        .DATA_W(DATA_W), .TAG_W(TAG_W), .TS_W(TS_W), .DEPTH(DEPTH), .DROP_W(DROP_W)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    rec_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] m_ts = '0;
    int unsigned m_drops = 0;
    bit          m_ovf = 1'b0;
    bit          m_valid = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit r, input bit cv, input logic [7:0] tg, input logic [31:0] dt,
                        input bit frz, input bit rdy);
        int   lvl;
        bit   pop;
        bit   cap;
        bit   push;
        rec_t head;
        rst           = r;
        bus.cap_valid = cv;
        bus.cap_tag   = tg;
        bus.cap_data  = dt;
        bus.freeze    = frz;
        bus.out_ready = rdy;
        #1;
        lvl = sb.size();
        if (m_valid) begin
            check("level", 64'(bus.level), 64'(lvl));
            check("ovf", 64'(bus.ovf), 64'(m_ovf));
            check("out_valid", 64'(bus.out_valid), 64'(lvl != 0));
        end
        pop = !r && (lvl != 0) && rdy;
        if (pop) begin
            head = sb.pop_front();
            check("out_tag", 64'(bus.out_tag), 64'(head.tag));
            check("out_data", 64'(bus.out_data), 64'(head.data));
            check("out_ts", 64'(bus.out_ts), 64'(head.ts));
            check("out_drops", 64'(bus.out_drops), 64'(head.drops));
        end
        cap  = !r && cv && !frz;
        push = cap && ((lvl < int'(DEPTH)) || pop);
        if (push) begin
            sb.push_back('{tag: tg, data: dt, ts: m_ts, drops: 8'(m_drops)});
            m_drops = 0;
        end else if (cap) begin
            if (m_drops < 255) m_drops++;
            m_ovf = 1'b1;
        end
        if (r) begin
            sb.delete();
            m_drops = 0;
            m_ovf   = 1'b0;
        end
        @(posedge clk);
        m_ts = r ? 32'd0 : m_ts + 32'd1;
        if (r) m_valid = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 64) begin
            step(0, 0, 8'h0, 32'h0, 0, 1);
            guard++;
        end
        check("drain_empty", 64'(bus.out_valid), 64'(0));
    endtask

    task automatic check_zero_outputs();
        check("rst_out_tag", 64'(bus.out_tag), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        check("rst_out_ts", 64'(bus.out_ts), 64'(0));
        check("rst_out_drops", 64'(bus.out_drops), 64'(0));
        check("rst_level", 64'(bus.level), 64'(0));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_ovf", 64'(bus.ovf), 64'(0));
    endtask

    initial begin
        bus.cap_valid = 1'b0;
        bus.cap_tag   = '0;
        bus.cap_data  = '0;
        bus.freeze    = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        step(1, 0, 8'h0, 32'h0, 0, 0);
        step(1, 0, 8'h0, 32'h0, 0, 0);
        check_zero_outputs();

        // Three pushes held, then drained in order.
        step(0, 1, 8'h01, 32'hA, 0, 0);
        step(0, 1, 8'h02, 32'hB, 0, 0);
        step(0, 1, 8'h03, 32'hC, 0, 0);
        check("t1_level", 64'(bus.level), 64'(3));
        drain();

        // Overflow: 20 captures into a 16-deep FIFO.
        for (int i = 0; i < 20; i++) step(0, 1, 8'(8'h10 + i), 32'(i * 3), 0, 0);
        check("t2_level", 64'(bus.level), 64'(16));
        check("t2_ovf", 64'(bus.ovf), 64'(1));
        step(0, 0, 8'h0, 32'h0, 0, 1);
        step(0, 1, 8'h55, 32'h5555, 0, 0);
        check("t2_refull", 64'(bus.level), 64'(16));

        // Full with simultaneous push and pop: accepted, no drop.
        step(0, 1, 8'h66, 32'h6666, 0, 1);
        check("t3_level", 64'(bus.level), 64'(16));

        // 300 drops saturate the drop counter.
        for (int i = 0; i < 300; i++) step(0, 1, 8'hEE, 32'(i), 0, 0);
        step(0, 0, 8'h0, 32'h0, 0, 1);
        step(0, 1, 8'hAA, 32'hAAAA, 0, 0);
        drain();

        // Reset in the middle of a drain at level 7.
        for (int i = 0; i < 8; i++) step(0, 1, 8'(8'h30 + i), 32'(i + 100), 0, 0);
        step(0, 0, 8'h0, 32'h0, 0, 1);
        check("t6_level7", 64'(bus.level), 64'(7));
        step(1, 1, 8'h99, 32'h9999, 0, 1);
        check_zero_outputs();
        step(0, 1, 8'h77, 32'h7777, 0, 0);
        check("t6_ts_restart", 64'(bus.out_ts), 64'(0));
        drain();

        // freeze ignores captures without counting drops; ts keeps running.
        step(0, 1, 8'h41, 32'h1, 0, 0);
        step(0, 1, 8'h42, 32'h2, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 8'hF0, 32'(i), 1, 0);
        check("t5_level", 64'(bus.level), 64'(2));
        check("t5_ovf", 64'(bus.ovf), 64'(0));
        step(0, 1, 8'h43, 32'h3, 0, 0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
